// File: rtl/gpio_bank.sv
// rtl/gpio_bank.sv - multi-port GPIO for the light8080 IO space with atomic writes and edge interrupts
module gpio_bank #(
  parameter int         NPORTS      = 2,
  parameter int         WIDTH       = 8,
  parameter logic [7:0] BASE_ADDR   = 8'h84,
  parameter int         SYNC_STAGES = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [7:0]               io_addr,
  input  logic                     io_wr,
  input  logic                     io_rd,
  input  logic [7:0]               io_din,
  output logic [7:0]               io_dout,
  output logic                     io_hit,
  input  logic [NPORTS*WIDTH-1:0]  pin_in,
  output logic [NPORTS*WIDTH-1:0]  pin_out,
  output logic [NPORTS*WIDTH-1:0]  pin_oe,
  output logic [NPORTS-1:0]        irq,
  output logic                     irq_any
);

  localparam int         NB         = NPORTS * WIDTH;
  localparam logic [2:0] SETTLE_MAX = 3'(SYNC_STAGES + 1);
  localparam logic [8:0] WINDOW     = 9'(NPORTS * 8);

  logic [NB-1:0]     r_out, r_dir, r_ie, r_pol, r_iflag, r_prev;
  logic [NB-1:0]     r_sync [SYNC_STAGES];
  logic [2:0]        r_settle;
  logic [NPORTS-1:0] r_irq;
  logic [7:0]        r_dout;
  logic              r_hit;

  logic [8:0]        w_rel;
  logic              w_sel;
  logic [2:0]        w_port, w_reg;
  logic [WIDTH-1:0]  w_wdata, w_rsel;
  logic [NB-1:0]     w_out_nxt, w_dir_nxt, w_ie_nxt, w_pol_nxt, w_w1c;
  logic [NB-1:0]     w_sync, w_rise, w_fall, w_evt;
  logic [NPORTS-1:0] w_irq_nxt;

  // Nine-bit subtract so addresses below BASE_ADDR borrow out instead of wrapping into the window.
  assign w_rel   = {1'b0, io_addr} - {1'b0, BASE_ADDR};
  assign w_sel   = !w_rel[8] && (w_rel < WINDOW);
  assign w_port  = w_rel[5:3];
  assign w_reg   = w_rel[2:0];
  assign w_wdata = WIDTH'(io_din);

  always_comb begin
    w_out_nxt = r_out;
    w_dir_nxt = r_dir;
    w_ie_nxt  = r_ie;
    w_pol_nxt = r_pol;
    w_w1c     = '0;
    for (int p = 0; p < NPORTS; p++) begin
      if (io_wr && w_sel && (w_port == 3'(p))) begin
        case (w_reg)
          3'd0:    w_out_nxt[p*WIDTH +: WIDTH] = w_wdata;
          3'd1:    w_dir_nxt[p*WIDTH +: WIDTH] = w_wdata;
          3'd2:    w_out_nxt[p*WIDTH +: WIDTH] = r_out[p*WIDTH +: WIDTH] | w_wdata;
          3'd3:    w_out_nxt[p*WIDTH +: WIDTH] = r_out[p*WIDTH +: WIDTH] & ~w_wdata;
          3'd4:    w_out_nxt[p*WIDTH +: WIDTH] = r_out[p*WIDTH +: WIDTH] ^ w_wdata;
          3'd5:    w_ie_nxt[p*WIDTH +: WIDTH]  = w_wdata;
          3'd6:    w_pol_nxt[p*WIDTH +: WIDTH] = w_wdata;
          default: w_w1c[p*WIDTH +: WIDTH]     = w_wdata;
        endcase
      end
    end
  end

  always_comb begin
    w_rsel = '0;
    for (int p = 0; p < NPORTS; p++) begin
      if (w_port == 3'(p)) begin
        case (w_reg)
          3'd0:    w_rsel = w_sync[p*WIDTH +: WIDTH];
          3'd1:    w_rsel = r_dir[p*WIDTH +: WIDTH];
          3'd5:    w_rsel = r_ie[p*WIDTH +: WIDTH];
          3'd6:    w_rsel = r_pol[p*WIDTH +: WIDTH];
          3'd7:    w_rsel = r_iflag[p*WIDTH +: WIDTH];
          default: w_rsel = r_out[p*WIDTH +: WIDTH];
        endcase
      end
    end
  end

  // Edges are masked until the sync chain and prev have flushed their reset zeros.
  assign w_sync = r_sync[SYNC_STAGES-1];
  assign w_rise = w_sync & ~r_prev;
  assign w_fall = ~w_sync & r_prev;
  assign w_evt  = (r_settle == SETTLE_MAX) ? ((r_pol & w_fall) | (~r_pol & w_rise)) : '0;

  always_comb begin
    w_irq_nxt = '0;
    for (int p = 0; p < NPORTS; p++) begin
      w_irq_nxt[p] = |(r_iflag[p*WIDTH +: WIDTH] & r_ie[p*WIDTH +: WIDTH]);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_out    <= '0;
      r_dir    <= '0;
      r_ie     <= '0;
      r_pol    <= '0;
      r_iflag  <= '0;
      r_prev   <= '0;
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
      r_settle <= '0;
      r_irq    <= '0;
      r_dout   <= '0;
      r_hit    <= 1'b0;
    end else begin
      r_out    <= w_out_nxt;
      r_dir    <= w_dir_nxt;
      r_ie     <= w_ie_nxt;
      r_pol    <= w_pol_nxt;
      r_iflag  <= (r_iflag & ~w_w1c) | w_evt;
      r_sync[0] <= pin_in;
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
      r_prev   <= w_sync;
      if (r_settle != SETTLE_MAX) r_settle <= r_settle + 3'd1;
      r_irq    <= w_irq_nxt;
      r_hit    <= io_rd && w_sel;
      if (io_rd && w_sel) r_dout <= 8'(w_rsel);
    end
  end

  assign pin_out = r_out;
  assign pin_oe  = r_dir;
  assign irq     = r_irq;
  assign irq_any = |r_irq;
  assign io_dout = r_dout;
  assign io_hit  = r_hit;

endmodule

// File: tb/tb_gpio_bank.sv
// tb/tb_gpio_bank.sv - directed vector bench for gpio_bank (2x8 and 4x5 instances)
module tb_gpio_bank;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  io_addr = 8'h00;
  logic        io_wr = 1'b0;
  logic        io_rd = 1'b0;
  logic [7:0]  io_din = 8'h00;
  logic [7:0]  io_dout;
  logic        io_hit;
  logic [15:0] pin_in = 16'h0000;
  logic [15:0] pin_out, pin_oe;
  logic [1:0]  irq;
  logic        irq_any;

  logic [7:0]  io_dout4;
  logic        io_hit4;
  logic [19:0] pin_in4 = 20'h00000;
  logic [19:0] pin_out4, pin_oe4;
  logic [3:0]  irq4;
  logic        irq_any4;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  gpio_bank #(.NPORTS(2), .WIDTH(8), .BASE_ADDR(8'h84), .SYNC_STAGES(2)) dut (
    .clock(clock), .reset(reset), .io_addr(io_addr), .io_wr(io_wr), .io_rd(io_rd),
    .io_din(io_din), .io_dout(io_dout), .io_hit(io_hit), .pin_in(pin_in),
    .pin_out(pin_out), .pin_oe(pin_oe), .irq(irq), .irq_any(irq_any)
  );

  gpio_bank #(.NPORTS(4), .WIDTH(5), .BASE_ADDR(8'h84), .SYNC_STAGES(2)) dut4 (
    .clock(clock), .reset(reset), .io_addr(io_addr), .io_wr(io_wr), .io_rd(io_rd),
    .io_din(io_din), .io_dout(io_dout4), .io_hit(io_hit4), .pin_in(pin_in4),
    .pin_out(pin_out4), .pin_oe(pin_oe4), .irq(irq4), .irq_any(irq_any4)
  );

  typedef struct {
    logic        wr;
    logic        rd;
    logic [7:0]  addr;
    logic [7:0]  din;
    logic [15:0] pin;
    logic [7:0]  dout;
    logic        hit;
    logic [15:0] out;
    logic [15:0] oe;
    logic [1:0]  irq;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic wr, input logic rd, input logic [7:0] addr, input logic [7:0] din,
                     input logic [15:0] pin, input logic [7:0] dout, input logic hit,
                     input logic [15:0] out, input logic [15:0] oe, input logic [1:0] q);
    vec_t v;
    v = '{wr, rd, addr, din, pin, dout, hit, out, oe, q};
    tbl.push_back(v);
  endtask

  task automatic cyc(input logic wr, input logic rd, input logic [7:0] addr,
                     input logic [7:0] din, input logic [15:0] pin);
    @(negedge clock);
    io_wr = wr; io_rd = rd; io_addr = addr; io_din = din; pin_in = pin;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clock);
    io_wr = 1'b0; io_rd = 1'b0;
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin : main
    logic [7:0] lat_exp [4];

    // Register-map vectors, applied back to back after the first reset.
    for (int a = 8'h84; a <= 8'h93; a++) add(0, 1, 8'(a), 8'h00, 16'h0, 8'h00, 1, 16'h0, 16'h0, 2'b00);
    add(0, 1, 8'h94, 8'h00, 16'h0, 8'h00, 0, 16'h0000, 16'h0000, 2'b00);
    add(0, 1, 8'h83, 8'h00, 16'h0, 8'h00, 0, 16'h0000, 16'h0000, 2'b00);
    add(1, 0, 8'h85, 8'hFF, 16'h0, 8'h00, 0, 16'h0000, 16'h00FF, 2'b00);
    add(1, 0, 8'h84, 8'hA5, 16'h0, 8'h00, 0, 16'h00A5, 16'h00FF, 2'b00);
    add(1, 0, 8'h86, 8'h0A, 16'h0, 8'h00, 0, 16'h00AF, 16'h00FF, 2'b00);
    add(1, 0, 8'h87, 8'h80, 16'h0, 8'h00, 0, 16'h002F, 16'h00FF, 2'b00);
    add(1, 0, 8'h88, 8'h03, 16'h0, 8'h00, 0, 16'h002C, 16'h00FF, 2'b00);
    add(0, 1, 8'h86, 8'h00, 16'h0, 8'h2C, 1, 16'h002C, 16'h00FF, 2'b00);
    add(0, 1, 8'h87, 8'h00, 16'h0, 8'h2C, 1, 16'h002C, 16'h00FF, 2'b00);
    add(0, 1, 8'h88, 8'h00, 16'h0, 8'h2C, 1, 16'h002C, 16'h00FF, 2'b00);
    add(0, 1, 8'h85, 8'h00, 16'h0, 8'hFF, 1, 16'h002C, 16'h00FF, 2'b00);
    add(1, 0, 8'h89, 8'h3C, 16'h0, 8'h00, 0, 16'h002C, 16'h00FF, 2'b00);
    add(0, 1, 8'h89, 8'h00, 16'h0, 8'h3C, 1, 16'h002C, 16'h00FF, 2'b00);
    add(1, 0, 8'h8A, 8'hC3, 16'h0, 8'h00, 0, 16'h002C, 16'h00FF, 2'b00);
    add(0, 1, 8'h8A, 8'h00, 16'h0, 8'hC3, 1, 16'h002C, 16'h00FF, 2'b00);
    add(1, 0, 8'h94, 8'hFF, 16'h0, 8'h00, 0, 16'h002C, 16'h00FF, 2'b00);
    add(1, 0, 8'h83, 8'hFF, 16'h0, 8'h00, 0, 16'h002C, 16'h00FF, 2'b00);
    add(0, 1, 8'h84, 8'h00, 16'h0, 8'h00, 1, 16'h002C, 16'h00FF, 2'b00);
    add(0, 1, 8'h8C, 8'h00, 16'h5A00, 8'h00, 1, 16'h002C, 16'h00FF, 2'b00);
    add(0, 1, 8'h8C, 8'h00, 16'h5A00, 8'h00, 1, 16'h002C, 16'h00FF, 2'b00);
    add(0, 1, 8'h8C, 8'h00, 16'h5A00, 8'h5A, 1, 16'h002C, 16'h00FF, 2'b00);
    add(0, 1, 8'h93, 8'h00, 16'h5A00, 8'h5A, 1, 16'h002C, 16'h00FF, 2'b00);
    add(1, 0, 8'h91, 8'h02, 16'h5A00, 8'h00, 0, 16'h002C, 16'h00FF, 2'b00);
    add(0, 1, 8'h91, 8'h00, 16'h5A00, 8'h02, 1, 16'h002C, 16'h00FF, 2'b10);
    add(1, 0, 8'h93, 8'h5A, 16'h5A00, 8'h00, 0, 16'h002C, 16'h00FF, 2'b10);
    add(0, 1, 8'h93, 8'h00, 16'h5A00, 8'h00, 1, 16'h002C, 16'h00FF, 2'b00);

    repeat (3) @(posedge clock);
    #1;
    chk("reset pin_out", pin_out, 16'h0);
    chk("reset pin_oe", pin_oe, 16'h0);
    chk("reset irq", {irq_any, irq}, 3'b000);
    chk("reset io_dout", io_dout, 8'h00);
    chk("reset io_hit", io_hit, 1'b0);
    @(negedge clock);
    reset = 1'b0;

    foreach (tbl[i]) begin
      cyc(tbl[i].wr, tbl[i].rd, tbl[i].addr, tbl[i].din, tbl[i].pin);
      if (tbl[i].rd) chk($sformatf("vec%0d dout", i), io_dout, tbl[i].dout);
      chk($sformatf("vec%0d hit", i), io_hit, tbl[i].hit);
      chk($sformatf("vec%0d out", i), pin_out, tbl[i].out);
      chk($sformatf("vec%0d oe", i), pin_oe, tbl[i].oe);
      chk($sformatf("vec%0d irq", i), irq, tbl[i].irq);
    end

    // Rising edge on pin 8: flag appears SYNC_STAGES edges after sampling, irq one edge later.
    do_reset();
    repeat (4) cyc(0, 0, 8'h00, 8'h00, 16'h0000);
    cyc(1, 0, 8'h91, 8'h01, 16'h0000);
    cyc(1, 0, 8'h92, 8'h00, 16'h0000);
    lat_exp = '{8'h00, 8'h00, 8'h00, 8'h01};
    for (int k = 0; k < 4; k++) begin
      cyc(0, 1, 8'h93, 8'h00, 16'h0100);
      chk($sformatf("latency k+%0d iflag", k), io_dout, lat_exp[k]);
      chk($sformatf("latency k+%0d irq", k), {irq_any, irq}, {lat_exp[k][0], lat_exp[k][0], 1'b0});
    end
    cyc(1, 0, 8'h93, 8'h01, 16'h0100);
    chk("w1c irq same edge", irq, 2'b10);
    cyc(0, 0, 8'h00, 8'h00, 16'h0100);
    chk("w1c irq dropped", {irq_any, irq}, 3'b000);

    // Falling polarity on bit 9, then an un-enabled rising flag on bit 8.
    do_reset();
    cyc(1, 0, 8'h92, 8'h02, 16'h0000);
    cyc(1, 0, 8'h91, 8'h02, 16'h0000);
    repeat (4) cyc(0, 0, 8'h00, 8'h00, 16'h0200);
    cyc(0, 1, 8'h93, 8'h00, 16'h0200);
    chk("pol fall no flag on rise", io_dout, 8'h00);
    repeat (3) cyc(0, 0, 8'h00, 8'h00, 16'h0000);
    cyc(0, 1, 8'h93, 8'h00, 16'h0000);
    chk("pol fall flag", io_dout, 8'h02);
    chk("pol fall irq", {irq_any, irq}, 3'b110);
    cyc(1, 0, 8'h93, 8'h02, 16'h0000);
    cyc(0, 0, 8'h00, 8'h00, 16'h0000);
    chk("pol fall irq cleared", irq, 2'b00);
    repeat (3) cyc(0, 0, 8'h00, 8'h00, 16'h0100);
    cyc(0, 1, 8'h93, 8'h00, 16'h0100);
    chk("ie clear flag set", io_dout, 8'h01);
    chk("ie clear irq low", irq, 2'b00);
    cyc(1, 0, 8'h91, 8'h03, 16'h0100);
    chk("ie set irq not yet", irq, 2'b00);
    cyc(0, 0, 8'h00, 8'h00, 16'h0100);
    chk("ie set irq", irq, 2'b10);

    // Pins high through reset release must not flag; event beats a same-cycle W1C.
    @(negedge clock);
    pin_in = 16'hFFFF;
    do_reset();
    repeat (5) cyc(0, 0, 8'h00, 8'h00, 16'hFFFF);
    cyc(0, 1, 8'h8B, 8'h00, 16'hFFFF);
    chk("settle iflag0", io_dout, 8'h00);
    cyc(0, 1, 8'h93, 8'h00, 16'hFFFF);
    chk("settle iflag1", io_dout, 8'h00);
    repeat (4) cyc(0, 0, 8'h00, 8'h00, 16'hFEFF);
    cyc(0, 0, 8'h00, 8'h00, 16'hFFFF);
    cyc(0, 0, 8'h00, 8'h00, 16'hFFFF);
    cyc(1, 0, 8'h93, 8'h01, 16'hFFFF);
    cyc(0, 1, 8'h93, 8'h00, 16'hFFFF);
    chk("set beats w1c", io_dout, 8'h01);
    cyc(1, 0, 8'h93, 8'h01, 16'hFFFF);
    cyc(0, 1, 8'h93, 8'h00, 16'hFFFF);
    chk("w1c alone clears", io_dout, 8'h00);

    // Asynchronous reset in the middle of a cycle with state everywhere.
    cyc(1, 0, 8'h85, 8'hF0, 16'h0000);
    cyc(1, 0, 8'h84, 8'h3C, 16'h0000);
    cyc(1, 0, 8'h91, 8'h01, 16'h0000);
    repeat (4) cyc(0, 0, 8'h00, 8'h00, 16'h0100);
    cyc(0, 1, 8'h85, 8'h00, 16'h0100);
    chk("pre-reset irq", irq, 2'b10);
    chk("pre-reset dout", io_dout, 8'hF0);
    #1 reset = 1'b1;
    #1;
    chk("async reset pin_out", pin_out, 16'h0);
    chk("async reset pin_oe", pin_oe, 16'h0);
    chk("async reset irq", {irq_any, irq}, 3'b000);
    chk("async reset dout/hit", {io_dout, io_hit}, 9'h000);
    @(negedge clock);
    io_rd = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    repeat (4) cyc(0, 0, 8'h00, 8'h00, 16'h0100);
    cyc(0, 1, 8'h93, 8'h00, 16'h0100);
    chk("flags lost after reset", io_dout, 8'h00);

    // Four ports of five pins: port 3 at 0x9C..0xA3, upper data bits read 0.
    cyc(1, 0, 8'h9D, 8'hFF, 16'h0000);
    chk("p4 dir3 oe", pin_oe4, 20'hF8000);
    cyc(1, 0, 8'h9C, 8'hFF, 16'h0000);
    chk("p4 data3 out", pin_out4, 20'hF8000);
    cyc(1, 0, 8'hA0, 8'h21, 16'h0000);
    chk("p4 tgl3 out", pin_out4, 20'hF0000);
    cyc(0, 1, 8'hA0, 8'h00, 16'h0000);
    chk("p4 tgl3 read", {io_hit4, io_dout4}, 9'h11E);
    chk("p2 outside window", io_hit, 1'b0);
    cyc(0, 1, 8'h9D, 8'h00, 16'h0000);
    chk("p4 dir3 read", {io_hit4, io_dout4}, 9'h11F);
    cyc(0, 1, 8'hA4, 8'h00, 16'h0000);
    chk("p4 past window", {io_hit4, io_dout4}, 9'h01F);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/gpio_bank.md
Name: gpio_bank

Overview:
- Parametrised multi-port GPIO peripheral for the light8080 SOC 8-bit IO space; generalises the fixed two-port data/direction pair.
- Adds atomic set/clear/toggle writes, input synchronisers, per-pin edge interrupts with selectable polarity, and a per-port interrupt request.
- Pad tri-stating stays at top level; this block drives pin_out/pin_oe and samples pin_in.

Parameters:
- NPORTS, 2, number of ports (1..8).
- WIDTH, 8, pins per port (1..8); unused data bits read 0, ignored on write.
- BASE_ADDR, 8'h84, IO address of port 0 offset 0; port p occupies BASE_ADDR+8*p .. +7.
- SYNC_STAGES, 2, input synchroniser flops (2..3).

Ports:
- clock  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- io_addr  in  8  CPU IO address (cpu_addr[7:0]).
- io_wr  in  1  IO write strobe (cpu_wr & cpu_io), one cycle per write.
- io_rd  in  1  IO read qualifier (cpu_io).
- io_din  in  8  CPU write data.
- io_dout  out  8  registered read data.
- io_hit  out  1  registered: previous-cycle io_rd address decoded to this block.
- pin_in  in  NPORTS*WIDTH  pad inputs, port p at [p*WIDTH +: WIDTH], asynchronous.
- pin_out  out  NPORTS*WIDTH  output register values.
- pin_oe  out  NPORTS*WIDTH  output enables (1 = drive).
- irq  out  NPORTS  per-port interrupt request, registered.
- irq_any  out  1  OR of irq.

Behaviour:
- Reset: all OUT, DIR, IE, POL, IFLAG = 0; sync chains and prev = 0; io_dout = 0; io_hit = 0; irq = 0; settle counter = 0. pin_oe = 0 (all inputs).
- Register map per port (offset: name, R/W):
  - 0 DATA: W loads OUT; R returns synchronised pins (pad value, incl. driven pins).
  - 1 DIR: R/W, 1 = output; pin_oe = DIR.
  - 2 SET: W OUT |= din; R returns OUT.
  - 3 CLR: W OUT &= ~din; R returns OUT.
  - 4 TGL: W OUT ^= din; R returns OUT.
  - 5 IE: R/W, per-pin interrupt enable.
  - 6 POL: R/W, 0 = rising edge, 1 = falling edge.
  - 7 IFLAG: R returns pending flags; W1C (bits written 1 cleared).
- Addresses outside NPORTS*8 window: no write effect, io_hit = 0, io_dout holds.
- Writes take effect at the clock edge where io_wr = 1; pin_out/pin_oe update that edge (no extra latency).
- Reads: on each edge with io_rd = 1 and address hit, io_dout <= selected value; io_hit <= 1. Otherwise io_dout holds, io_hit <= 0. Data valid one cycle after address, matching the SOC's sampled-io data mux. Reads have no side effects.
- Synchroniser: SYNC_STAGES flops per pin; sync = last stage; prev <= sync every cycle.
- Edge event: rise = sync & ~prev; fall = ~sync & prev; evt = POL ? fall : rise. Event sets IFLAG bit regardless of IE.
- Settle: 3-bit counter increments from 0 after reset release until SYNC_STAGES+1, then saturates; edge events are ignored while counting (no spurious flags from pins high at reset).
- Simultaneous event and W1C on same bit: set wins, flag stays 1.
- POL write same cycle as edge: event uses old POL.
- irq[p] <= |(IFLAG & IE) of port p (one cycle after flag/IE change). irq_any = |irq. Level-held until flags cleared or IE cleared.
- Reset mid-operation clears everything immediately, asynchronously; flags lost.
- Input-to-flag latency: pin change sampled at edge k sets IFLAG at edge k+SYNC_STAGES; irq one edge later.

Test Plan:
- Reset, then read each port offset 0..7 with pin_in = 0 -> io_dout = 0x00, pin_oe = 0, irq = 0. Read addr 0x94 (NPORTS=2) -> io_hit = 0.
- Write DIR0 = 0xFF, DATA0 = 0xA5, SET0 = 0x0A, CLR0 = 0x80, TGL0 = 0x03 -> pin_out[7:0] = 0xA5, 0xAF, 0x2F, 0x2C; read 0x86 -> 0x2C one cycle later with io_hit = 1.
- Port1 IE = 0x01, POL = 0. Raise pin_in[8] -> IFLAG1 = 0x01 after SYNC_STAGES edges; irq[1] = 1 next cycle. Write 0x01 to 0x93 -> irq[1] drops one cycle later.
- POL1 = 0x02, IE = 0x02. Pulse pin_in[9] high for 5 cycles -> no flag on rise; flag 0x02 on fall; a rising pulse on bit 0 with IE bit clear sets IFLAG bit 0 but irq stays 0 until IE = 0x03.
- Hold pin_in = all 1 through reset release -> no IFLAG bits set. Fire edge in same cycle as W1C of that bit -> flag remains 1.
- Set flags, assert reset for 1 cycle mid-traffic -> all outputs 0. Repeat bench with NPORTS = 4, WIDTH = 5 -> port 3 at 0x9C..0xA3; bits [7:5] read 0.
